// File: rtl/rv_trap_ctrl_if.sv
// Signal bundle between the commit stage / CSR file / fetch and the
// machine-mode trap sequencer. The sequencer connects through the slave
// modport; the surrounding pipeline (or a bench) drives the master side.
interface rv_trap_ctrl_if #(
  parameter int XLEN = 32
);
  logic            exc_valid;
  logic [3:0]      exc_cause;
  logic [XLEN-1:0] exc_pc;
  logic [XLEN-1:0] exc_tval;
  logic            mret_valid;
  logic [XLEN-1:0] commit_pc;
  logic            irq_ext;
  logic            irq_sw;
  logic            irq_timer;
  logic            csr_mstatus_mie;
  logic [XLEN-1:0] csr_mie;
  logic [XLEN-1:0] csr_mtvec;
  logic [XLEN-1:0] csr_mepc;
  logic            flush_req;
  logic            flush_ack;
  logic            busy;
  logic            trap_wr;
  logic [XLEN-1:0] trap_mepc;
  logic [XLEN-1:0] trap_mcause;
  logic [XLEN-1:0] trap_mtval;
  logic            mret_wr;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output exc_valid, exc_cause, exc_pc, exc_tval, mret_valid, commit_pc,
           irq_ext, irq_sw, irq_timer, csr_mstatus_mie, csr_mie, csr_mtvec,
           csr_mepc, flush_ack,
    input  flush_req, busy, trap_wr, trap_mepc, trap_mcause, trap_mtval,
           mret_wr, redirect_valid, redirect_pc
  );

  modport slave (
    input  exc_valid, exc_cause, exc_pc, exc_tval, mret_valid, commit_pc,
           irq_ext, irq_sw, irq_timer, csr_mstatus_mie, csr_mie, csr_mtvec,
           csr_mepc, flush_ack,
    output flush_req, busy, trap_wr, trap_mepc, trap_mcause, trap_mtval,
           mret_wr, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/rv_trap_ctrl.sv
// Machine-mode trap sequencer: picks one event (exception, interrupt or
// MRET) in IDLE, flushes the pipeline, pulses the CSR update and then
// redirects fetch. Every output comes straight from a flop.
module rv_trap_ctrl #(
  parameter int XLEN = 32
) (
  input logic         clk,
  input logic         rstn,
  rv_trap_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FLUSH, UPDATE, REDIRECT} state_t;
  typedef enum logic [1:0] {EV_EXC, EV_IRQ, EV_MRET} kind_t;

  state_t state_q, state_d;

  // Latched event. mepc_q holds the word-aligned PC that matters for the
  // event: faulting PC, interrupted PC, or the MRET return address.
  kind_t           kind_q;
  logic [3:0]      cause_q;
  logic [XLEN-3:0] mepc_q;
  logic [XLEN-1:0] mtval_q;
  logic [XLEN-1:0] mtvec_q;

  logic            ev_valid;
  kind_t           ev_kind;
  logic [3:0]      ev_cause;
  logic            irq_ext_ok, irq_sw_ok, irq_timer_ok;

  logic            flush_req_d, busy_d, trap_wr_d, mret_wr_d, redirect_valid_d;
  logic [XLEN-1:0] trap_mepc_d, trap_mcause_d, trap_mtval_d, redirect_pc_d;
  logic [XLEN-1:0] mcause_val, base_pc, vec_off, target_pc;

  logic            unused_bits;
  assign unused_bits = ^{bus.exc_pc[1:0], bus.commit_pc[1:0], bus.csr_mepc[1:0],
                         bus.csr_mie[XLEN-1:12], bus.csr_mie[10:8],
                         bus.csr_mie[6:4], bus.csr_mie[2:0]};

  // Arbitration: exception beats interrupt beats MRET; ext > sw > timer
  always_comb begin
    irq_ext_ok   = bus.csr_mstatus_mie & bus.irq_ext   & bus.csr_mie[11];
    irq_sw_ok    = bus.csr_mstatus_mie & bus.irq_sw    & bus.csr_mie[3];
    irq_timer_ok = bus.csr_mstatus_mie & bus.irq_timer & bus.csr_mie[7];
    ev_valid = 1'b0;
    ev_kind  = EV_EXC;
    ev_cause = 4'd0;
    if (bus.exc_valid) begin
      ev_valid = 1'b1;
      ev_cause = bus.exc_cause;
    end else if (irq_ext_ok) begin
      ev_valid = 1'b1;
      ev_kind  = EV_IRQ;
      ev_cause = 4'd11;
    end else if (irq_sw_ok) begin
      ev_valid = 1'b1;
      ev_kind  = EV_IRQ;
      ev_cause = 4'd3;
    end else if (irq_timer_ok) begin
      ev_valid = 1'b1;
      ev_kind  = EV_IRQ;
      ev_cause = 4'd7;
    end else if (bus.mret_valid) begin
      ev_valid = 1'b1;
      ev_kind  = EV_MRET;
    end
  end

  // Next state plus next values of the registered outputs
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (ev_valid) state_d = FLUSH;
      FLUSH:    if (bus.flush_ack) state_d = UPDATE;
      UPDATE:   state_d = REDIRECT;
      REDIRECT: state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    mcause_val = (kind_q == EV_IRQ) ? {1'b1, {(XLEN-5){1'b0}}, cause_q}
                                    : {{(XLEN-4){1'b0}}, cause_q};
    base_pc    = {mtvec_q[XLEN-1:2], 2'b00};
    vec_off    = {{(XLEN-6){1'b0}}, cause_q, 2'b00};
    if (kind_q == EV_MRET)
      target_pc = {mepc_q, 2'b00};
    else if (kind_q == EV_IRQ && mtvec_q[1:0] == 2'b01)
      target_pc = base_pc + vec_off;
    else
      target_pc = base_pc;

    flush_req_d      = (state_d == FLUSH);
    busy_d           = (state_d != IDLE);
    trap_wr_d        = (state_d == UPDATE) && (kind_q != EV_MRET);
    mret_wr_d        = (state_d == UPDATE) && (kind_q == EV_MRET);
    redirect_valid_d = (state_d == REDIRECT);
    trap_mepc_d      = trap_wr_d ? {mepc_q, 2'b00} : '0;
    trap_mcause_d    = trap_wr_d ? mcause_val : '0;
    trap_mtval_d     = trap_wr_d ? mtval_q : '0;
    redirect_pc_d    = redirect_valid_d ? target_pc : '0;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Capture the chosen event and its CSR context at accept
  always_ff @(posedge clk) begin
    if (!rstn) begin
      kind_q  <= EV_EXC;
      cause_q <= 4'd0;
      mepc_q  <= '0;
      mtval_q <= '0;
      mtvec_q <= '0;
    end else if (state_q == IDLE && ev_valid) begin
      kind_q  <= ev_kind;
      cause_q <= ev_cause;
      mtvec_q <= bus.csr_mtvec;
      case (ev_kind)
        EV_EXC: begin
          mepc_q  <= bus.exc_pc[XLEN-1:2];
          mtval_q <= bus.exc_tval;
        end
        EV_IRQ: begin
          mepc_q  <= bus.commit_pc[XLEN-1:2];
          mtval_q <= '0;
        end
        default: begin
          mepc_q  <= bus.csr_mepc[XLEN-1:2];
          mtval_q <= '0;
        end
      endcase
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      bus.flush_req      <= 1'b0;
      bus.busy           <= 1'b0;
      bus.trap_wr        <= 1'b0;
      bus.mret_wr        <= 1'b0;
      bus.redirect_valid <= 1'b0;
      bus.trap_mepc      <= '0;
      bus.trap_mcause    <= '0;
      bus.trap_mtval     <= '0;
      bus.redirect_pc    <= '0;
    end else begin
      bus.flush_req      <= flush_req_d;
      bus.busy           <= busy_d;
      bus.trap_wr        <= trap_wr_d;
      bus.mret_wr        <= mret_wr_d;
      bus.redirect_valid <= redirect_valid_d;
      bus.trap_mepc      <= trap_mepc_d;
      bus.trap_mcause    <= trap_mcause_d;
      bus.trap_mtval     <= trap_mtval_d;
      bus.redirect_pc    <= redirect_pc_d;
    end
  end

endmodule
